// File: rtl/notes_tone_synth_if.sv
// Signal bundle between the note decoder side and the tone synthesiser.
`timescale 1ns/1ps
interface notes_tone_synth_if;
    logic [7:0] input_note_sel_3;
    logic       input_enable_4;
    logic       output_tone_5;
    logic       output_busy_6;
    logic [2:0] output_note_idx_7;
    logic       output_error_8;

    modport master (
        output input_note_sel_3,
        output input_enable_4,
        input  output_tone_5,
        input  output_busy_6,
        input  output_note_idx_7,
        input  output_error_8
    );

    modport slave (
        input  input_note_sel_3,
        input  input_enable_4,
        output output_tone_5,
        output output_busy_6,
        output output_note_idx_7,
        output output_error_8
    );
endinterface

// File: rtl/notes_tone_synth.sv
// Deglitches the one-hot note decode and drives a runt-free square wave.
`timescale 1ns/1ps
module notes_tone_synth #(
    parameter int PRESCALE = 1,
    parameter int SETTLE   = 4,
    parameter int CNT_W    = 16
) (
    input logic              input_clock1_1,
    input logic              input_reset1_2,
    notes_tone_synth_if.slave bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PLAY   = 2'd1;
    localparam logic [1:0] S_SWITCH = 2'd2;

    logic [7:0]       sel_q, sel_d;
    logic [7:0]       last_q, last_d;
    logic [3:0]       stab_q, stab_d;
    logic [1:0]       state_q, state_d;
    logic             tone_q, tone_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    pre_q, pre_d;

    logic       tick, settled, one_hot, multi_hot;
    logic       bnd, differs, apply;
    logic [2:0] sel_idx;

    function automatic logic [CNT_W-1:0] reload(input logic [2:0] i);
        unique case (i)
            3'd0:    reload = CNT_W'(477);
            3'd1:    reload = CNT_W'(425);
            3'd2:    reload = CNT_W'(378);
            3'd3:    reload = CNT_W'(357);
            3'd4:    reload = CNT_W'(318);
            3'd5:    reload = CNT_W'(283);
            3'd6:    reload = CNT_W'(252);
            default: reload = CNT_W'(238);
        endcase
    endfunction

    function automatic logic [2:0] enc(input logic [7:0] v);
        enc = 3'd0;
        for (int i = 0; i < 8; i++)
            if (v[i]) enc = 3'(i);
    endfunction

    function automatic logic is_one_hot(input logic [7:0] v);
        is_one_hot = (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    // sel_q doubles as the candidate: a new sample restarts the run at 1
    always_comb begin
        sel_d = bus.input_note_sel_3;
        if (sel_d != sel_q)
            stab_d = 4'd1;
        else if (stab_q != 4'(SETTLE))
            stab_d = stab_q + 4'd1;
        else
            stab_d = stab_q;
    end

    assign tick      = (pre_q == PW'(PRESCALE - 1));
    assign pre_d     = tick ? '0 : pre_q + PW'(1);
    assign settled   = (stab_q == 4'(SETTLE));
    assign one_hot   = is_one_hot(sel_q);
    assign multi_hot = (sel_q != 8'd0) && !one_hot;
    assign sel_idx   = enc(sel_q);
    assign last_d    = settled ? sel_q : last_q;
    assign bnd       = tick && (cnt_q == '0);
    assign differs   = settled && !(one_hot && sel_idx == idx_q);

    always_comb begin
        state_d = state_q;
        tone_d  = tone_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        apply   = 1'b0;
        if (!bus.input_enable_4) begin
            state_d = S_IDLE;
            tone_d  = 1'b0;
            idx_d   = 3'd0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (settled && one_hot) begin
                        state_d = S_PLAY;
                        tone_d  = 1'b1;
                        idx_d   = sel_idx;
                        cnt_d   = reload(sel_idx);
                    end
                end
                S_PLAY, S_SWITCH: begin
                    // changes only land while the output is, or is about to be, low
                    if ((differs || state_q == S_SWITCH) &&
                        (!tone_q || bnd)) begin
                        apply = 1'b1;
                    end else begin
                        if (differs) state_d = S_SWITCH;
                        if (bnd) begin
                            tone_d = ~tone_q;
                            cnt_d  = reload(idx_q);
                        end else if (tick) begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (apply) begin
                tone_d = 1'b0;
                if (is_one_hot(last_d)) begin
                    state_d = S_PLAY;
                    idx_d   = enc(last_d);
                    cnt_d   = reload(enc(last_d));
                end else begin
                    state_d = S_IDLE;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                end
            end
        end
    end

    always_ff @(posedge input_clock1_1) begin
        if (input_reset1_2) begin
            sel_q   <= '0;
            last_q  <= '0;
            stab_q  <= '0;
            state_q <= S_IDLE;
            tone_q  <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            pre_q   <= '0;
        end else begin
            sel_q   <= sel_d;
            last_q  <= last_d;
            stab_q  <= stab_d;
            state_q <= state_d;
            tone_q  <= tone_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
        end
    end

    assign bus.output_tone_5     = tone_q;
    assign bus.output_busy_6     = (state_q != S_IDLE);
    assign bus.output_note_idx_7 = idx_q;
    assign bus.output_error_8    = settled && multi_hot;
endmodule

// File: tb/tb_notes_tone_synth.sv
// Bench for notes_tone_synth: directed scenarios plus random stimulus
`timescale 1ns/1ps
module tb_notes_tone_synth;
    localparam int SETTLE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    notes_tone_synth_if bus();

    notes_tone_synth #(
        .PRESCALE(1),
        .SETTLE(SETTLE),
        .CNT_W(16)
    ) dut (
        .input_clock1_1(clk),
        .input_reset1_2(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int half [8] = '{478, 426, 379, 358, 319, 284, 253, 239};

    // reference model: sample history, phase length remaining, pending flag
    logic [7:0] hq [$];
    logic       m_play, m_sw, m_tone, m_err;
    logic [2:0] m_idx;
    int         m_rem;
    logic [7:0] m_last, m_sv, m_eff;
    logic       m_st, m_bnd, m_chg;

    function automatic logic m_settled();
        if (hq.size() < SETTLE) return 1'b0;
        for (int i = 0; i < hq.size(); i++)
            if (hq[i] !== hq[hq.size() - 1]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [2:0] pos(input logic [7:0] v);
        for (int i = 0; i < 8; i++)
            if (v[i]) return 3'(i);
        return 3'd0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            hq.delete();
            m_play = 0; m_sw = 0; m_tone = 0;
            m_idx = 0; m_rem = 0; m_last = 0;
        end else begin
            m_st  = m_settled();
            m_sv  = m_st ? hq[hq.size() - 1] : 8'h00;
            m_eff = m_st ? m_sv : m_last;
            if (!bus.input_enable_4) begin
                m_play = 0; m_sw = 0; m_tone = 0; m_idx = 0;
            end else if (!m_play) begin
                if (m_st && $countones(m_sv) == 1) begin
                    m_play = 1; m_tone = 1;
                    m_idx = pos(m_sv); m_rem = half[m_idx];
                end
            end else begin
                m_bnd = (m_rem == 1);
                m_chg = m_st && !($countones(m_sv) == 1 && pos(m_sv) == m_idx);
                if ((m_chg || m_sw) && (!m_tone || m_bnd)) begin
                    m_sw = 0; m_tone = 0;
                    if ($countones(m_eff) == 1) begin
                        m_idx = pos(m_eff); m_rem = half[m_idx];
                    end else begin
                        m_play = 0; m_idx = 0;
                    end
                end else begin
                    if (m_chg) m_sw = 1;
                    if (m_bnd) begin
                        m_tone = !m_tone; m_rem = half[m_idx];
                    end else begin
                        m_rem--;
                    end
                end
            end
            if (m_st) m_last = m_sv;
            hq.push_back(bus.input_note_sel_3);
            if (hq.size() > SETTLE) void'(hq.pop_front());
        end
        m_err = m_settled() && ($countones(hq[hq.size() - 1]) > 1);
    end

    logic [5:0] obs, expv;
    assign obs  = {bus.output_tone_5, bus.output_busy_6,
                   bus.output_note_idx_7, bus.output_error_8};
    assign expv = {m_tone, m_play, m_idx, m_err};

    task automatic measure(input logic lvl, output int n);
        n = 0;
        while (bus.output_tone_5 === lvl && n < 3000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_rise(output int n);
        n = 0;
        while (bus.output_tone_5 !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1; bus.input_note_sel_3 = 8'h00; bus.input_enable_4 = 1;
        repeat (3) @(negedge clk);
        total++;
        if (obs !== 6'b0) begin
            bad++; $display("FAIL reset outs=%b want=000000", obs);
        end
        total++;
        if (obs !== expv) begin
            bad++; $display("FAIL reset_model dut=%b model=%b", obs, expv);
        end
    endtask

    task automatic test_latency();
        int n;
        rst = 0; bus.input_note_sel_3 = 8'h01;
        wait_rise(n);
        total++;
        if (n != SETTLE + 1) begin
            bad++; $display("FAIL latency got=%0d want=%0d", n, SETTLE + 1);
        end
        total++;
        if (bus.output_busy_6 !== 1 || bus.output_note_idx_7 !== 3'd0) begin
            bad++; $display("FAIL play_c6 busy=%b idx=%0d want 1/0",
                            bus.output_busy_6, bus.output_note_idx_7);
        end
        measure(1'b1, n);
        total++;
        if (n != 478) begin bad++; $display("FAIL c6_high got=%0d want=478", n); end
        measure(1'b0, n);
        total++;
        if (n != 478) begin bad++; $display("FAIL c6_low got=%0d want=478", n); end
        measure(1'b1, n);
        total++;
        if (n != 478) begin bad++; $display("FAIL c6_high2 got=%0d want=478", n); end
    endtask

    task automatic test_glitch();
        int n;
        int odd = 0;
        bus.input_note_sel_3 = 8'h10;
        repeat (2) begin
            @(negedge clk);
            if (bus.output_note_idx_7 !== 0 || bus.output_error_8 !== 0) odd++;
        end
        bus.input_note_sel_3 = 8'h01;
        measure(1'b0, n);
        total++;
        if (n != 476) begin bad++; $display("FAIL glitch_low got=%0d want=476", n); end
        total++;
        if (odd != 0 || bus.output_note_idx_7 !== 0 || bus.output_error_8 !== 0) begin
            bad++; $display("FAIL glitch_idx_err idx=%0d err=%b odd=%0d want 0/0/0",
                            bus.output_note_idx_7, bus.output_error_8, odd);
        end
    endtask

    task automatic test_switch();
        int n;
        repeat (10) @(negedge clk);
        bus.input_note_sel_3 = 8'h80;
        measure(1'b1, n);
        total++;
        if (n != 468) begin bad++; $display("FAIL sw_high_rest got=%0d want=468", n); end
        total++;
        if (bus.output_note_idx_7 !== 3'd7) begin
            bad++; $display("FAIL sw_idx got=%0d want=7", bus.output_note_idx_7);
        end
        measure(1'b0, n);
        total++;
        if (n != 239) begin bad++; $display("FAIL c7_low got=%0d want=239", n); end
    endtask

    task automatic test_invalid();
        int n;
        bus.input_note_sel_3 = 8'h03;
        repeat (5) @(negedge clk);
        total++;
        if (bus.output_error_8 !== 1 || bus.output_busy_6 !== 1) begin
            bad++; $display("FAIL inv_err err=%b busy=%b want 1/1",
                            bus.output_error_8, bus.output_busy_6);
        end
        measure(1'b1, n);
        total++;
        if (n != 234) begin bad++; $display("FAIL inv_high got=%0d want=234", n); end
        total++;
        if (bus.output_busy_6 !== 0 || bus.output_note_idx_7 !== 0) begin
            bad++; $display("FAIL inv_stop busy=%b idx=%0d want 0/0",
                            bus.output_busy_6, bus.output_note_idx_7);
        end
        bus.input_note_sel_3 = 8'h00;
        repeat (5) @(negedge clk);
        total++;
        if (bus.output_error_8 !== 0 || bus.output_tone_5 !== 0) begin
            bad++; $display("FAIL inv_clear err=%b tone=%b want 0/0",
                            bus.output_error_8, bus.output_tone_5);
        end
    endtask

    task automatic test_enable();
        int n;
        bus.input_note_sel_3 = 8'h01;
        wait_rise(n);
        repeat (100) @(negedge clk);
        bus.input_enable_4 = 0;
        @(negedge clk);
        total++;
        if (obs !== 6'b0) begin bad++; $display("FAIL en_off outs=%b want=000000", obs); end
        repeat (3) @(negedge clk);
        bus.input_enable_4 = 1;
        @(negedge clk);
        total++;
        if (bus.output_tone_5 !== 1) begin bad++; $display("FAIL en_on tone=0 want=1"); end
        measure(1'b1, n);
        total++;
        if (n != 478) begin bad++; $display("FAIL en_high got=%0d want=478", n); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bus.input_note_sel_3 = 8'h20;
        while (!(bus.output_tone_5 === 1 && bus.output_note_idx_7 === 3'd5) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (50) @(negedge clk);
        rst = 1;
        @(negedge clk);
        total++;
        if (obs !== 6'b0) begin bad++; $display("FAIL rst_mid outs=%b want=000000", obs); end
        rst = 0;
        wait_rise(n);
        total++;
        if (n != SETTLE + 1) begin
            bad++; $display("FAIL rst_latency got=%0d want=%0d", n, SETTLE + 1);
        end
    endtask

    task automatic test_random();
        int left = 0;
        int r;
        logic [7:0] v;
        for (int c = 0; c < 9000; c++) begin
            if (left == 0) begin
                r = $urandom_range(0, 9);
                if (r < 2) begin
                    v = 8'h01 << $urandom_range(0, 7);
                    left = $urandom_range(1, 3);
                end else if (r == 2) begin
                    v = 8'h00;
                    left = $urandom_range(10, 300);
                end else if (r == 3) begin
                    do v = 8'($urandom); while ($countones(v) < 2);
                    left = $urandom_range(10, 300);
                end else begin
                    v = 8'h01 << $urandom_range(0, 7);
                    left = $urandom_range(100, 1500);
                end
                bus.input_note_sel_3 = v;
                bus.input_enable_4 = ($urandom_range(0, 19) != 0);
            end
            left--;
            @(negedge clk);
            total++;
            if (obs !== expv) begin
                bad++; $display("FAIL random c=%0d dut=%b model=%b", c, obs, expv);
            end
        end
    endtask

    initial begin
        bus.input_note_sel_3 = 8'h00;
        bus.input_enable_4 = 1;
        @(negedge clk);
        test_reset();
        test_latency();
        test_glitch();
        test_switch();
        test_invalid();
        test_enable();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
